// File: rtl/hsid_pkg.sv
// rtl/hsid_pkg.sv - shared HSID datapath constants
// Ports: none (package).
package hsid_pkg;

  localparam int HSID_WORD_WIDTH       = 32;
  localparam int HSID_MEM_ACCESS_WIDTH = 16;
  // Byte stride between consecutive word addresses.
  localparam int HSID_WORD_BYTES       = HSID_WORD_WIDTH / 8;

endpackage

// File: rtl/hsid_x_obi_inf_pkg.sv
// rtl/hsid_x_obi_inf_pkg.sv - OBI request/response types and memory-writer state encoding
// Ports: none (package).
package hsid_x_obi_inf_pkg;

  import hsid_pkg::*;

  typedef struct packed {
    logic                       req;
    logic                       we;
    logic [HSID_WORD_BYTES-1:0] be;
    logic [HSID_WORD_WIDTH-1:0] addr;
    logic [HSID_WORD_WIDTH-1:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic gnt;
    logic rvalid;
    logic err;
  } obi_resp_t;

  typedef enum logic [1:0] {
    WR_IDLE  = 2'd0,
    WR_WRITE = 2'd1,
    WR_DONE  = 2'd2,
    WR_CLEAR = 2'd3
  } hsid_x_obi_mem_wr_state_t;

endpackage

// File: rtl/hsid_x_obi_mem_wr_if.sv
// rtl/hsid_x_obi_mem_wr_if.sv - OBI bus plus input word stream of the memory writer
// Signals: obi_req/obi_rsp (OBI channel), data_in/data_in_valid/data_in_ready (word stream).
// Modports: master = the writer block, slave = memory side and word producer.
interface hsid_x_obi_mem_wr_if;

  import hsid_pkg::*;
  import hsid_x_obi_inf_pkg::*;

  obi_req_t                   obi_req;
  obi_resp_t                  obi_rsp;
  logic [HSID_WORD_WIDTH-1:0] data_in;
  logic                       data_in_valid;
  logic                       data_in_ready;

  modport master (
    output obi_req,
    output data_in_ready,
    input  obi_rsp,
    input  data_in,
    input  data_in_valid
  );

  modport slave (
    input  obi_req,
    input  data_in_ready,
    output obi_rsp,
    output data_in,
    output data_in_valid
  );

endinterface

// File: rtl/hsid_x_obi_outstanding_cnt.sv
// rtl/hsid_x_obi_outstanding_cnt.sv - up/down counter of granted writes awaiting rvalid
// Ports: clk, rst_n; inc_i (req && gnt), dec_i (rvalid); count_o (current), count_next_o (after this edge).
module hsid_x_obi_outstanding_cnt #(
  parameter int MAX = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       inc_i,
  input  logic                       dec_i,
  output logic [$clog2(MAX+1)-1:0]   count_o,
  output logic [$clog2(MAX+1)-1:0]   count_next_o
);

  localparam int W = $clog2(MAX + 1);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;
  logic         dec_eff;

  // A response with nothing outstanding is spurious and dropped.
  assign dec_eff = dec_i && (count_q != '0);

  always_comb begin
    count_d = count_q;
    if (inc_i && !dec_eff) begin
      count_d = (count_q == W'(MAX)) ? count_q : count_q + W'(1);
    end else if (!inc_i && dec_eff) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count_o      = count_q;
  assign count_next_o = count_d;

endmodule

// File: rtl/hsid_x_obi_mem_wr.sv
// rtl/hsid_x_obi_mem_wr.sv - OBI write initiator storing a word stream to consecutive addresses
// Ports: clk, rst_n; bus (master: obi_req/obi_rsp, data_in stream); initial_addr, limit (sampled on start);
//        start, clear (control); idle, ready, done (state flags); err (sticky bus error).
module hsid_x_obi_mem_wr
  import hsid_pkg::*;
  import hsid_x_obi_inf_pkg::*;
#(
  parameter int WORD_WIDTH       = HSID_WORD_WIDTH,
  parameter int MEM_ACCESS_WIDTH = HSID_MEM_ACCESS_WIDTH,
  parameter int MAX_OUTSTANDING  = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  hsid_x_obi_mem_wr_if.master         bus,
  input  logic [WORD_WIDTH-1:0]       initial_addr,
  input  logic [MEM_ACCESS_WIDTH-1:0] limit,
  input  logic                        start,
  input  logic                        clear,
  output logic                        idle,
  output logic                        ready,
  output logic                        done,
  output logic                        err
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);

  hsid_x_obi_mem_wr_state_t    state_q;
  logic [WORD_WIDTH-1:0]       addr_q;
  logic [MEM_ACCESS_WIDTH-1:0] limit_q;
  logic [MEM_ACCESS_WIDTH-1:0] issued_q;
  obi_req_t                    req_q;
  logic                        err_q;

  logic          pending;
  logic          gnt_now;
  logic          rsp_now;
  logic          beat;
  logic          drained;
  logic [CW-1:0] outst;
  logic [CW-1:0] outst_next;

  assign pending = req_q.req;
  assign gnt_now = pending && bus.obi_rsp.gnt;
  assign rsp_now = bus.obi_rsp.rvalid && (outst != '0);

  hsid_x_obi_outstanding_cnt #(
    .MAX(MAX_OUTSTANDING)
  ) u_outstanding (
    .clk          (clk),
    .rst_n        (rst_n),
    .inc_i        (gnt_now),
    .dec_i        (bus.obi_rsp.rvalid),
    .count_o      (outst),
    .count_next_o (outst_next)
  );

  // A grant this cycle frees the request register for a new beat; the
  // post-edge outstanding count must leave room for that beat. A beat is
  // never taken alongside clear so an abort cannot launch one more write.
  assign bus.data_in_ready = (state_q == WR_WRITE) && !clear
                          && (issued_q < limit_q)
                          && (!pending || bus.obi_rsp.gnt)
                          && (int'(outst_next) < MAX_OUTSTANDING);
  assign beat = bus.data_in_valid && bus.data_in_ready;

  // Nothing in flight after this edge (only evaluated where no beat can be taken).
  assign drained = !(pending && !bus.obi_rsp.gnt) && (outst_next == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= WR_IDLE;
      addr_q   <= '0;
      limit_q  <= '0;
      issued_q <= '0;
      req_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      if (beat) begin
        req_q    <= '{req: 1'b1, we: 1'b1, be: '1, addr: addr_q, wdata: bus.data_in};
        addr_q   <= addr_q + WORD_WIDTH'(HSID_WORD_BYTES);
        issued_q <= issued_q + MEM_ACCESS_WIDTH'(1);
      end else if (gnt_now) begin
        req_q <= '0;
      end

      if (rsp_now && bus.obi_rsp.err) err_q <= 1'b1;

      unique case (state_q)
        WR_IDLE: begin
          if (clear) begin
            err_q <= 1'b0;
          end else if (start) begin
            state_q  <= WR_WRITE;
            addr_q   <= initial_addr;
            limit_q  <= limit;
            issued_q <= '0;
            err_q    <= 1'b0;
          end
        end
        WR_WRITE: begin
          if (clear) begin
            state_q <= WR_CLEAR;
            err_q   <= 1'b0;
          end else if ((issued_q == limit_q) && drained) begin
            state_q <= WR_DONE;
          end
        end
        WR_DONE: begin
          if (clear) begin
            state_q <= WR_CLEAR;
            err_q   <= 1'b0;
          end else begin
            state_q <= WR_IDLE;
          end
        end
        WR_CLEAR: begin
          if (drained) state_q <= WR_IDLE;
        end
        default: state_q <= WR_IDLE;
      endcase
    end
  end

  assign bus.obi_req = req_q;
  assign idle        = (state_q == WR_IDLE);
  assign ready       = (state_q == WR_WRITE);
  assign done        = (state_q == WR_DONE);
  assign err         = err_q;

endmodule

// File: tb/tb_hsid_x_obi_mem_wr.sv
// tb/tb_hsid_x_obi_mem_wr.sv - randomized self-checking bench for the OBI memory writer
module tb_hsid_x_obi_mem_wr;

  import hsid_x_obi_inf_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] initial_addr;
  logic [15:0] limit;
  logic        start;
  logic        clear;
  logic        idle, ready, done, err;

  always #5 clk = ~clk;

  hsid_x_obi_mem_wr_if bus_if ();

  hsid_x_obi_mem_wr #(
    .WORD_WIDTH(32),
    .MEM_ACCESS_WIDTH(16),
    .MAX_OUTSTANDING(2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus_if),
    .initial_addr (initial_addr),
    .limit        (limit),
    .start        (start),
    .clear        (clear),
    .idle         (idle),
    .ready        (ready),
    .done         (done),
    .err          (err)
  );

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scenario configuration and observation state.
  int          cyc = 0;
  bit          rand_mode = 0, stall_alt = 0, active_src = 0, clear_sent = 0;
  int          clear_after = 0, err_idx = -1, cur_limit = 0;
  logic [31:0] src_data [32];
  int          n_src = 0, src_idx = 0, beats = 0;
  logic [31:0] wr_addr [$];
  logic [31:0] wr_data [$];
  int          resp_due [$];
  int          resp_cnt = 0, gnt_wait = 0, outst = 0, max_outst = 0;
  int          stab_err = 0, fld_err = 0;
  bit          hold = 0;
  obi_req_t    snap;
  int          ready_cnt = 0, done_cnt = 0, req_cnt = 0, zero_flag_cnt = 0, multi_flag = 0;
  int          ready_after_last = 0, ready_first = -1, done_cyc = -1, last_rv_cyc = -1;
  int          first_beat_cyc = -1, last_beat_cyc = -1, start_cyc = 0;

  // Memory slave and word source: drive just after the rising edge, observe at the falling edge.
  initial begin
    bus_if.obi_rsp       = '0;
    bus_if.data_in       = '0;
    bus_if.data_in_valid = 1'b0;
    clear                = 1'b0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      bus_if.obi_rsp.gnt    = rand_mode ? (bus_if.obi_req.req && gnt_wait == 0) : 1'b1;
      bus_if.obi_rsp.rvalid = (resp_due.size() > 0) && (resp_due[0] <= cyc);
      bus_if.obi_rsp.err    = bus_if.obi_rsp.rvalid && (resp_cnt == err_idx);
      bus_if.data_in_valid  = active_src && (src_idx < n_src) && (!stall_alt || cyc[0]);
      bus_if.data_in        = src_data[src_idx < 32 ? src_idx : 0];
      clear = (clear_after > 0) && (beats >= clear_after) && !clear_sent;
      if (clear) clear_sent = 1;

      @(negedge clk);
      if (bus_if.obi_req.req) req_cnt++;
      if (ready) begin ready_cnt++; if (ready_first < 0) ready_first = cyc; end
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (!idle && !ready && !done) zero_flag_cnt++;
      if (int'(idle) + int'(ready) + int'(done) > 1) multi_flag++;
      if (hold && (bus_if.obi_req !== snap)) stab_err++;
      hold = bus_if.obi_req.req && !bus_if.obi_rsp.gnt;
      snap = bus_if.obi_req;
      if (bus_if.obi_req.req && bus_if.obi_rsp.gnt) begin
        wr_addr.push_back(bus_if.obi_req.addr);
        wr_data.push_back(bus_if.obi_req.wdata);
        if (!(bus_if.obi_req.we && bus_if.obi_req.be == 4'hF)) fld_err++;
        resp_due.push_back(cyc + 1 + (rand_mode ? int'($urandom_range(0, 3)) : 0));
        outst++;
        gnt_wait = rand_mode ? int'($urandom_range(0, 3)) : 0;
      end else if (bus_if.obi_req.req && gnt_wait > 0) begin
        gnt_wait--;
      end
      if (bus_if.obi_rsp.rvalid) begin
        void'(resp_due.pop_front());
        resp_cnt++;
        outst--;
        last_rv_cyc = cyc;
      end
      if (outst > max_outst) max_outst = outst;
      if (bus_if.data_in_ready && beats >= cur_limit) ready_after_last++;
      if (bus_if.data_in_valid && bus_if.data_in_ready) begin
        src_idx++;
        beats++;
        if (beats == 1) first_beat_cyc = cyc;
        last_beat_cyc = cyc;
      end
    end
  end

  task automatic run_xfer(input logic [31:0] a, input int lim, input bit rnd, input bit stall,
                          input int clr_after, input int eidx);
    bit reached;
    @(posedge clk);
    #2;
    wr_addr.delete(); wr_data.delete(); resp_due.delete();
    resp_cnt = 0; outst = 0; max_outst = 0; gnt_wait = 0; hold = 0;
    stab_err = 0; fld_err = 0; beats = 0; src_idx = 0; n_src = lim;
    ready_cnt = 0; done_cnt = 0; req_cnt = 0; zero_flag_cnt = 0; multi_flag = 0;
    ready_after_last = 0; ready_first = -1; done_cyc = -1; last_rv_cyc = -1;
    first_beat_cyc = -1; last_beat_cyc = -1;
    rand_mode = rnd; stall_alt = stall; clear_after = clr_after; clear_sent = 0;
    err_idx = eidx; cur_limit = lim;
    initial_addr = a; limit = 16'(lim); start = 1'b1; start_cyc = cyc; active_src = 1;
    @(posedge clk);
    #2 start = 1'b0;
    reached = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      #1;
      if (idle) begin reached = 1; break; end
    end
    check_eq("idle_reached", reached, 1);
    active_src = 0;
    rand_mode = 0;
  endtask

  // Reference: word i lands at a + 4*i (mod 2^32) carrying the i-th source word.
  task automatic check_writes(input string tag, input logic [31:0] a, input int n);
    logic [31:0] ea;
    check_eq({tag, "_count"}, wr_addr.size(), n);
    for (int i = 0; i < n && i < wr_addr.size(); i++) begin
      ea = a + 32'(4 * i);
      check_eq($sformatf("%s_addr%0d", tag, i), wr_addr[i], ea);
      check_eq($sformatf("%s_data%0d", tag, i), wr_data[i], src_data[i]);
    end
  endtask

  initial begin
    start = 1'b0;
    initial_addr = '0;
    limit = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_obi_req", bus_if.obi_req == '0, 1);
    check_eq("rst_ready_in", bus_if.data_in_ready, 0);
    check_eq("rst_flags", {idle, ready, done, err}, 4'b1000);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Sequential write, gnt/rvalid always on.
    for (int i = 0; i < 32; i++) src_data[i] = 32'hA0 + 32'(i);
    run_xfer(32'h100, 8, 0, 0, 0, -1);
    check_writes("seq", 32'h100, 8);
    check_eq("seq_done_pulses", done_cnt, 1);
    check_eq("seq_done_timing", done_cyc, last_rv_cyc + 1);
    check_eq("seq_ready_latency", ready_first, start_cyc + 1);
    check_eq("seq_throughput", last_beat_cyc - first_beat_cyc, 7);
    check_eq("seq_err", err, 0);

    // Address wrap across 2^32.
    for (int i = 0; i < 32; i++) src_data[i] = $urandom;
    run_xfer(32'hFFFF_FFF8, 4, 0, 0, 0, -1);
    check_writes("wrap", 32'hFFFF_FFF8, 4);
    check_eq("wrap_err", err, 0);

    // Random gnt/rvalid delays, one error response injected.
    for (int i = 0; i < 32; i++) src_data[i] = $urandom;
    run_xfer(32'h2000, 30, 1, 0, 0, 7);
    check_writes("rnd", 32'h2000, 30);
    check_eq("rnd_max_outst_le2", max_outst <= 2, 1);
    check_eq("rnd_stable", stab_err, 0);
    check_eq("rnd_fields", fld_err, 0);
    check_eq("rnd_err_sticky", err, 1);
    check_eq("rnd_done_pulses", done_cnt, 1);

    // Source stalls on alternate cycles.
    for (int i = 0; i < 32; i++) src_data[i] = $urandom;
    run_xfer(32'h3000, 10, 0, 1, 0, -1);
    check_writes("stall", 32'h3000, 10);
    check_eq("stall_ready_after_last", ready_after_last, 0);
    check_eq("stall_err_cleared", err, 0);

    // Zero-length transfer.
    run_xfer(32'h4000, 0, 0, 0, 0, -1);
    check_eq("lim0_reqs", req_cnt, 0);
    check_eq("lim0_ready_cycles", ready_cnt, 1);
    check_eq("lim0_done_cycles", done_cnt, 1);
    check_eq("lim0_done_after_ready", done_cyc, ready_first + 1);

    // Abort after five beats with delayed grants.
    for (int i = 0; i < 32; i++) src_data[i] = $urandom;
    run_xfer(32'h5000, 20, 1, 0, 5, -1);
    check_writes("clr", 32'h5000, 5);
    check_eq("clr_beats", beats, 5);
    check_eq("clr_zero_flags_seen", zero_flag_cnt > 0, 1);
    check_eq("clr_multi_flags", multi_flag, 0);
    check_eq("clr_no_done", done_cnt, 0);
    check_eq("clr_stable", stab_err, 0);

    // Normal run after the abort.
    for (int i = 0; i < 32; i++) src_data[i] = $urandom;
    run_xfer(32'h6000, 3, 0, 0, 0, -1);
    check_writes("post", 32'h6000, 3);
    check_eq("post_done_pulses", done_cnt, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
